// File: rtl/div_mon_pkg.sv
// Shared types and constants for the divider error monitor.
package div_mon_pkg;
  localparam int DVD_W     = 16;
  localparam int DVS_W     = 8;
  localparam int N_ITER    = 8;
  localparam int CNT_W_DEF = 32;
  localparam int SUM_W_DEF = 40;

  typedef enum logic [1:0] {IDLE, CALC, UPDATE} state_e;

  // |v| for a 9-bit two's-complement difference of two 8-bit values; always fits 8 bits.
  function automatic logic [DVS_W-1:0] abs_err(input logic [DVS_W:0] v);
    logic [DVS_W:0] n;
    n = -v;
    return v[DVS_W] ? n[DVS_W-1:0] : v[DVS_W-1:0];
  endfunction
endpackage

// File: rtl/div_err_monitor_if.sv
// Sample-in / result-out bus between the approximate divider and the error monitor.
interface div_err_monitor_if import div_mon_pkg::*; ();
  logic             in_valid;
  logic             in_ready;
  logic [DVD_W-1:0] x;
  logic [DVS_W-1:0] y;
  logic [DVS_W-1:0] q_app;
  logic [DVS_W-1:0] r_app;
  logic             res_valid;
  logic             res_skip;
  logic [DVS_W-1:0] q_exact;
  logic [DVS_W-1:0] r_exact;
  logic [DVS_W:0]   err_dist;

  modport master (
    output in_valid, x, y, q_app, r_app,
    input  in_ready, res_valid, res_skip, q_exact, r_exact, err_dist
  );
  modport slave (
    input  in_valid, x, y, q_app, r_app,
    output in_ready, res_valid, res_skip, q_exact, r_exact, err_dist
  );
endinterface

// File: rtl/div_serial_core.sv
// Serial restoring divider, one quotient bit per cycle. done is high during the last
// iteration; q/r are stable from the following cycle until the next start.
module div_serial_core import div_mon_pkg::*; (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [DVD_W-1:0] dvd,
  input  logic [DVS_W-1:0] dvs,
  output logic             done,
  output logic [DVS_W-1:0] q,
  output logic [DVS_W-1:0] r
);
  localparam int CW = $clog2(N_ITER);

  logic [DVS_W:0]   p;
  logic [DVS_W:0]   ps;
  logic [DVS_W-1:0] dl;
  logic [DVS_W-1:0] d;
  logic [CW-1:0]    cnt;
  logic             busy;
  logic             ge;

  assign ps   = {p[DVS_W-1:0], dl[DVS_W-1]};
  assign ge   = ps >= {1'b0, d};
  assign done = busy && (cnt == CW'(N_ITER-1));
  assign r    = p[DVS_W-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p    <= '0;
      dl   <= '0;
      d    <= '0;
      q    <= '0;
      cnt  <= '0;
      busy <= 1'b0;
    end else if (start) begin
      p    <= {1'b0, dvd[DVD_W-1:DVS_W]};
      dl   <= dvd[DVS_W-1:0];
      d    <= dvs;
      q    <= '0;
      cnt  <= '0;
      busy <= 1'b1;
    end else if (busy) begin
      p    <= ge ? ps - {1'b0, d} : ps;
      q    <= {q[DVS_W-2:0], ge};
      dl   <= {dl[DVS_W-2:0], 1'b0};
      cnt  <= cnt + 1'b1;
      if (done) busy <= 1'b0;
    end
  end
endmodule

// File: rtl/div_err_monitor.sv
// Exact-vs-approximate 16/8 divider error monitor with saturating statistics.
// Build option: DIV_MON_MAX_EN enables the max |err_dist| tracker (tied to 0 otherwise).
module div_err_monitor import div_mon_pkg::*; #(
  parameter int CNT_W = CNT_W_DEF,
  parameter int SUM_W = SUM_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  div_err_monitor_if.slave bus,
  input  logic             clear,
  output logic [CNT_W-1:0] sample_cnt,
  output logic [CNT_W-1:0] skip_cnt,
  output logic [CNT_W-1:0] err_cnt,
  output logic [SUM_W-1:0] sum_abs_err,
  output logic [DVS_W-1:0] max_abs_err
);
  state_e st, st_nx;
  logic             start, accept, in_rng, done;
  logic             skip_q;
  logic [DVS_W-1:0] qa_q, ra_q, core_q, core_r;
  logic [DVS_W:0]   err;
  logic [DVS_W-1:0] abs_e;
  logic             mis;
  logic [SUM_W:0]   sum_nx;
  logic             upd;

  assign in_rng       = (bus.y != '0) && (bus.x[DVD_W-1:DVS_W] < bus.y);
  assign bus.in_ready = (st == IDLE) && !rst;
  assign accept       = bus.in_valid && (st == IDLE);
  assign upd          = (st == UPDATE);

  div_serial_core u_core (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .dvd   (bus.x),
    .dvs   (bus.y),
    .done  (done),
    .q     (core_q),
    .r     (core_r)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) st <= IDLE;
    else     st <= st_nx;
  end

  always_comb begin
    st_nx = st;
    start = 1'b0;
    case (st)
      IDLE: if (accept) begin
        if (in_rng) begin
          start = 1'b1;
          st_nx = CALC;
        end else begin
          st_nx = UPDATE;
        end
      end
      CALC:    if (done) st_nx = UPDATE;
      UPDATE:  st_nx = IDLE;
      default: st_nx = IDLE;
    endcase
  end

  assign err    = {1'b0, qa_q} - {1'b0, core_q};
  assign abs_e  = abs_err(err);
  assign mis    = (qa_q != core_q) || (ra_q != core_r);
  assign sum_nx = {1'b0, sum_abs_err} + (SUM_W+1)'(abs_e);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      skip_q <= 1'b0;
      qa_q   <= '0;
      ra_q   <= '0;
    end else if (accept) begin
      skip_q <= !in_rng;
      qa_q   <= bus.q_app;
      ra_q   <= bus.r_app;
    end
  end

  // Per-sample outputs: skip samples report zeros; values hold until the next UPDATE.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.res_valid <= 1'b0;
      bus.res_skip  <= 1'b0;
      bus.q_exact   <= '0;
      bus.r_exact   <= '0;
      bus.err_dist  <= '0;
    end else begin
      bus.res_valid <= upd;
      if (upd) begin
        bus.res_skip <= skip_q;
        bus.q_exact  <= skip_q ? '0 : core_q;
        bus.r_exact  <= skip_q ? '0 : core_r;
        bus.err_dist <= skip_q ? '0 : err;
      end
    end
  end

  // clear has priority over the UPDATE of the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sample_cnt  <= '0;
      skip_cnt    <= '0;
      err_cnt     <= '0;
      sum_abs_err <= '0;
    end else if (clear) begin
      sample_cnt  <= '0;
      skip_cnt    <= '0;
      err_cnt     <= '0;
      sum_abs_err <= '0;
    end else if (upd) begin
      if (skip_q) begin
        if (~&skip_cnt) skip_cnt <= skip_cnt + 1'b1;
      end else begin
        if (~&sample_cnt)    sample_cnt <= sample_cnt + 1'b1;
        if (mis && ~&err_cnt) err_cnt   <= err_cnt + 1'b1;
        sum_abs_err <= sum_nx[SUM_W] ? '1 : sum_nx[SUM_W-1:0];
      end
    end
  end

`ifdef DIV_MON_MAX_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst)                                    max_abs_err <= '0;
    else if (clear)                             max_abs_err <= '0;
    else if (upd && !skip_q && abs_e > max_abs_err) max_abs_err <= abs_e;
  end
`else
  assign max_abs_err = '0;
`endif
endmodule
